elastic_config_loader: RTL and testbench

// - Writer side of the ElasticPE config-load interface. Accepts a stream of packed context words over the SELF valid/stop handshake and writes them into one PE's config memory.
// - Indices run 0..N-1. After the last write it pulses start_exec and drives mapping_context_max_id = N-1.
// - It then holds busy until the array reports exec_done.
// - Sits between the host/DMA config stream and the PE config ports.

---
 rtl/elastic_config_loader.sv | 217 +++++++++++++++++++++
 tb/tb_elastic_config_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_config_loader.sv
// Writer side of the ElasticPE config-load interface: streams N packed context words into one
// PE's config memory, then pulses start_exec. Optional checksum word: ELASTIC_CONFIG_LOADER_CHECKSUM_EN.
module elastic_config_loader #(
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned INPUT_NUM_BIT_LENGTH    = 3,
    parameter int unsigned NEIGHBOR_PE_NUM         = 4,
    parameter int unsigned OPERATION_BIT_LENGTH    = 4,
    parameter int unsigned CONTEXT_SIZE            = 8,
    parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = 3,
    localparam int unsigned CFG_W = 2 * INPUT_NUM_BIT_LENGTH + NEIGHBOR_PE_NUM
                                    + OPERATION_BIT_LENGTH + DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               load_req,
    input  logic [CONTEXT_SIZE_BIT_LENGTH:0]   load_context_count,
    input  logic                               abort,
    input  logic                               exec_done,
    input  logic [CFG_W-1:0]                   cfg_word,
    input  logic                               valid_input,
    output logic                               stop_input,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic                               write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               busy,
    output logic                               load_error
);

    localparam int unsigned CSBL     = CONTEXT_SIZE_BIT_LENGTH;
    localparam int unsigned INBL     = INPUT_NUM_BIT_LENGTH;
    localparam int unsigned CntW     = CSBL + 1;
    localparam int unsigned OffIn2   = INBL;
    localparam int unsigned OffOut   = 2 * INBL;
    localparam int unsigned OffOp    = OffOut + NEIGHBOR_PE_NUM;
    localparam int unsigned OffConst = OffOp + OPERATION_BIT_LENGTH;

    localparam logic [CSBL:0]   CntOne = {{CSBL{1'b0}}, 1'b1};
    localparam logic [CSBL-1:0] IdxOne = {{(CSBL-1){1'b0}}, 1'b1};
    localparam logic [CSBL:0]   CtxMax = CntW'(CONTEXT_SIZE);

    typedef enum logic [1:0] {StIdle, StLoad, StStart, StRun} state_e;

    state_e                       state_q, state_d;
    logic [CSBL:0]                cnt_q, cnt_d;
    logic [CSBL:0]                n_q, n_d;
    logic                         load_error_q, load_error_d;
    logic                         write_q, write_d;
    logic                         start_q, start_d;
    logic [CSBL-1:0]              index_q, index_d;
    logic [CSBL-1:0]              max_id_q, max_id_d;
    logic [INBL-1:0]              in1_q, in1_d;
    logic [INBL-1:0]              in2_q, in2_d;
    logic [NEIGHBOR_PE_NUM-1:0]   out_q, out_d;
    logic [OPERATION_BIT_LENGTH-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0]        const_q, const_d;
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    logic [CFG_W-1:0]             cks_q, cks_d;
    logic                         cks_phase_q, cks_phase_d;
`endif

    logic transfer;
    logic n_legal;

    assign stop_input = (state_q != StLoad) || abort;
    assign transfer   = valid_input && !stop_input;
    assign n_legal    = (load_context_count != '0) && (load_context_count <= CtxMax);
    assign busy       = (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        load_error_d = load_error_q;
        write_d      = 1'b0;
        start_d      = 1'b0;
        index_d      = index_q;
        max_id_d     = max_id_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        out_d        = out_q;
        op_d         = op_q;
        const_d      = const_q;
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
        cks_d        = cks_q;
        cks_phase_d  = cks_phase_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    if (n_legal) begin
                        state_d      = StLoad;
                        cnt_d        = '0;
                        n_d          = load_context_count;
                        load_error_d = 1'b0;
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
                        cks_d        = '0;
                        cks_phase_d  = 1'b0;
`endif
                    end else begin
                        load_error_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                // stop_input is high under abort, so no word can transfer in that cycle
                if (abort) begin
                    state_d = StIdle;
                end else if (transfer) begin
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
                    if (cks_phase_q) begin
                        if (cfg_word == cks_q) begin
                            state_d = StStart;
                        end else begin
                            load_error_d = 1'b1;
                            state_d      = StIdle;
                        end
                    end else begin
                        write_d = 1'b1;
                        index_d = cnt_q[CSBL-1:0];
                        in1_d   = cfg_word[0 +: INBL];
                        in2_d   = cfg_word[OffIn2 +: INBL];
                        out_d   = cfg_word[OffOut +: NEIGHBOR_PE_NUM];
                        op_d    = cfg_word[OffOp +: OPERATION_BIT_LENGTH];
                        const_d = cfg_word[OffConst +: DATA_WIDTH];
                        cnt_d   = cnt_q + CntOne;
                        cks_d   = cks_q ^ cfg_word;
                        if (cnt_q + CntOne == n_q) begin
                            cks_phase_d = 1'b1;
                        end
                    end
`else
                    write_d = 1'b1;
                    index_d = cnt_q[CSBL-1:0];
                    in1_d   = cfg_word[0 +: INBL];
                    in2_d   = cfg_word[OffIn2 +: INBL];
                    out_d   = cfg_word[OffOut +: NEIGHBOR_PE_NUM];
                    op_d    = cfg_word[OffOp +: OPERATION_BIT_LENGTH];
                    const_d = cfg_word[OffConst +: DATA_WIDTH];
                    cnt_d   = cnt_q + CntOne;
                    if (cnt_q + CntOne == n_q) begin
                        state_d = StStart;
                    end
`endif
                end
            end
            StStart: begin
                state_d  = StRun;
                start_d  = 1'b1;
                max_id_d = n_q[CSBL-1:0] - IdxOne;
            end
            StRun: begin
                if (abort || exec_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            n_q          <= '0;
            load_error_q <= 1'b0;
            write_q      <= 1'b0;
            start_q      <= 1'b0;
            index_q      <= '0;
            max_id_q     <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            out_q        <= '0;
            op_q         <= '0;
            const_q      <= '0;
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
            cks_q        <= '0;
            cks_phase_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            load_error_q <= load_error_d;
            write_q      <= write_d;
            start_q      <= start_d;
            index_q      <= index_d;
            max_id_q     <= max_id_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            out_q        <= out_d;
            op_q         <= op_d;
            const_q      <= const_d;
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
            cks_q        <= cks_d;
            cks_phase_q  <= cks_phase_d;
`endif
        end
    end

    assign config_input_PE_index_1 = in1_q;
    assign config_input_PE_index_2 = in2_q;
    assign config_output_PE_index  = out_q;
    assign config_op               = op_q;
    assign config_const_data       = const_q;
    assign write_config_data       = write_q;
    assign config_index            = index_q;
    assign start_exec              = start_q;
    assign mapping_context_max_id  = max_id_q;
    assign load_error              = load_error_q;

endmodule

// File: tb/tb_elastic_config_loader.sv
// Randomized scoreboard bench for elastic_config_loader: the driver predicts write strobes and
// start pulses (with cycle stamps) from the load rules; a negedge monitor pops and compares.
module tb_elastic_config_loader;

    localparam int DW    = 32;
    localparam int INBL  = 3;
    localparam int NPN   = 4;
    localparam int OPBL  = 4;
    localparam int CS    = 8;
    localparam int CSBL  = 3;
    localparam int CFG_W = 2 * INBL + NPN + OPBL + DW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              load_req;
    logic [CSBL:0]     load_context_count;
    logic              abort;
    logic              exec_done;
    logic [CFG_W-1:0]  cfg_word;
    logic              valid_input;
    logic              stop_input;
    logic [INBL-1:0]   config_input_PE_index_1;
    logic [INBL-1:0]   config_input_PE_index_2;
    logic [NPN-1:0]    config_output_PE_index;
    logic [OPBL-1:0]   config_op;
    logic [DW-1:0]     config_const_data;
    logic              write_config_data;
    logic [CSBL-1:0]   config_index;
    logic              start_exec;
    logic [CSBL-1:0]   mapping_context_max_id;
    logic              busy;
    logic              load_error;

    elastic_config_loader dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .load_req                (load_req),
        .load_context_count      (load_context_count),
        .abort                   (abort),
        .exec_done               (exec_done),
        .cfg_word                (cfg_word),
        .valid_input             (valid_input),
        .stop_input              (stop_input),
        .config_input_PE_index_1 (config_input_PE_index_1),
        .config_input_PE_index_2 (config_input_PE_index_2),
        .config_output_PE_index  (config_output_PE_index),
        .config_op               (config_op),
        .config_const_data       (config_const_data),
        .write_config_data       (write_config_data),
        .config_index            (config_index),
        .start_exec              (start_exec),
        .mapping_context_max_id  (mapping_context_max_id),
        .busy                    (busy),
        .load_error              (load_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit               is_start;
        int               cyc;
        int               idx;
        logic [CFG_W-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   model_max_id = 0;
    bit   model_err    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input bit is_start, input int c, input int idx, input logic [CFG_W-1:0] d);
        exp_t e;
        e.is_start = is_start;
        e.cyc      = c;
        e.idx      = idx;
        e.data     = d;
        sbq.push_back(e);
    endtask

    // Monitor: every strobe the DUT shows must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (write_config_data) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: index %0d at cycle %0d, none expected",
                             config_index, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("write_kind", 64'(e.is_start), 64'(0));
                    check("write_cycle", 64'(cyc), 64'(e.cyc));
                    check("write_index", 64'(config_index), 64'(e.idx));
                    check("write_word", 64'({config_const_data, config_op, config_output_PE_index,
                                             config_input_PE_index_2, config_input_PE_index_1}),
                          64'(e.data));
                end
            end
            if (start_exec) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_start: at cycle %0d, none expected", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("start_kind", 64'(e.is_start), 64'(1));
                    check("start_cycle", 64'(cyc), 64'(e.cyc));
                    check("start_max_id", 64'(mapping_context_max_id), 64'(e.idx));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            exec_done = ($urandom_range(0, 2) == 0);
            tick();
            exec_done = 1'b0;
            check("idle_busy", 64'(busy), 64'(0));
        end
        check("idle_load_error", 64'(load_error), 64'(model_err));
        check("idle_max_id", 64'(mapping_context_max_id), 64'(model_max_id));
    endtask

    task automatic do_load(input int n, input int gap, input int abort_at, input bit bad_cks);
        logic [CFG_W-1:0] w;
        logic [CFG_W-1:0] x;
        int               sent;
        bit               sent_now;
        int               run_cycles;
        load_req           = 1'b1;
        load_context_count = (CSBL + 1)'(n);
        tick();
        load_req = 1'b0;
        if (n < 1 || n > CS) begin
            model_err = 1'b1;
            check("bad_n_load_error", 64'(load_error), 64'(1));
            check("bad_n_busy", 64'(busy), 64'(0));
            check("bad_n_stop", 64'(stop_input), 64'(1));
            return;
        end
        model_err = 1'b0;
        check("accept_load_error", 64'(load_error), 64'(0));
        check("accept_busy", 64'(busy), 64'(1));
        sent = 0;
        x    = '0;
        while (sent < n) begin
            if (sent == abort_at) begin
                abort       = 1'b1;
                valid_input = 1'b1;
                cfg_word    = CFG_W'({$urandom, $urandom});
                #1;
                check("abort_stop", 64'(stop_input), 64'(1));
                tick();
                abort       = 1'b0;
                valid_input = 1'b0;
                check("abort_idle_busy", 64'(busy), 64'(0));
                check("abort_max_id", 64'(mapping_context_max_id), 64'(model_max_id));
                return;
            end
            sent_now = ($urandom_range(0, 99) >= gap);
            w        = CFG_W'({$urandom, $urandom});
            valid_input        = sent_now;
            cfg_word           = w;
            load_req           = ($urandom_range(0, 3) == 0);
            load_context_count = (CSBL + 1)'($urandom_range(0, 15));
            #1;
            check("load_stop", 64'(stop_input), 64'(0));
            tick();
            valid_input = 1'b0;
            load_req    = 1'b0;
            if (sent_now) begin
                push(1'b0, cyc, sent, w);
                x = x ^ w;
                sent++;
            end
        end
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
        valid_input = 1'b1;
        cfg_word    = bad_cks ? (x ^ CFG_W'($urandom_range(1, 1000))) : x;
        #1;
        check("cks_stop", 64'(stop_input), 64'(0));
        tick();
        valid_input = 1'b0;
        if (bad_cks) begin
            model_err = 1'b1;
            check("cks_bad_busy", 64'(busy), 64'(0));
            check("cks_bad_load_error", 64'(load_error), 64'(1));
            return;
        end
`else
        if (bad_cks) x = '0;
`endif
        push(1'b1, cyc + 1, n - 1, '0);
        model_max_id = n - 1;
        run_cycles = $urandom_range(1, 4);
        for (int i = 0; i < run_cycles; i++) begin
            load_req           = ($urandom_range(0, 1) == 1);
            load_context_count = (CSBL + 1)'($urandom_range(1, CS));
            tick();
            check("run_busy", 64'(busy), 64'(1));
        end
        load_req = 1'b0;
        if ($urandom_range(0, 3) == 0) abort = 1'b1;
        else exec_done = 1'b1;
        tick();
        abort     = 1'b0;
        exec_done = 1'b0;
        check("run_end_busy", 64'(busy), 64'(0));
        check("run_end_stop", 64'(stop_input), 64'(1));
    endtask

    initial begin
        int n;
        reset_n            = 1'b0;
        load_req           = 1'b0;
        load_context_count = '0;
        abort              = 1'b0;
        exec_done          = 1'b0;
        cfg_word           = '0;
        valid_input        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stop", 64'(stop_input), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_write", 64'(write_config_data), 64'(0));
        check("rst_start", 64'(start_exec), 64'(0));
        check("rst_load_error", 64'(load_error), 64'(0));
        check("rst_max_id", 64'(mapping_context_max_id), 64'(0));
        check("rst_index", 64'(config_index), 64'(0));
        check("rst_const", 64'(config_const_data), 64'(0));
        reset_n = 1'b1;
        tick();

        do_load(3, 0, 99, 1'b0);
        idle_gap(2);
        do_load(2, 60, 99, 1'b0);
        idle_gap(2);
        do_load(0, 0, 99, 1'b0);
        idle_gap(1);
        do_load(9, 0, 99, 1'b0);
        idle_gap(1);
        do_load(4, 0, 2, 1'b0);
        idle_gap(2);
        do_load(CS, 0, 99, 1'b0);
        idle_gap(1);
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
        do_load(2, 0, 99, 1'b1);
        idle_gap(1);
        do_load(2, 0, 99, 1'b0);
        idle_gap(1);
`endif
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(CS + 1, 15);
            end else begin
                n = $urandom_range(1, CS);
            end
            do_load(n, $urandom_range(0, 50),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, CS - 1) : 99,
                    ($urandom_range(0, 1) == 1));
            idle_gap($urandom_range(1, 3));
        end

        // Reset in the middle of a load returns everything to reset values.
        load_req           = 1'b1;
        load_context_count = 4'd4;
        tick();
        load_req    = 1'b0;
        valid_input = 1'b1;
        cfg_word    = CFG_W'({$urandom, $urandom});
        tick();
        valid_input = 1'b0;
        push(1'b0, cyc, 0, cfg_word);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_stop", 64'(stop_input), 64'(1));
        check("midrst_write", 64'(write_config_data), 64'(0));
        check("midrst_index", 64'(config_index), 64'(0));
        tick();
        reset_n      = 1'b1;
        model_max_id = 0;
        model_err    = 1'b0;
        idle_gap(3);

        repeat (3) tick();
        check("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
